// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  // Width of the shared ALU slice, in bits.
  localparam int NIB_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operation word in 74LS181 encoding: mode bit plus function select.
  typedef struct packed {
    logic       m;
    logic [3:0] s;
  } alu_op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is purely combinational from req and
// the remembered last winner; last_grant moves only when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  // Pick a winner: a lone requester always wins, a tie goes to the one not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of an accepted grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = gnt[1];
    end
  end

  // last_grant starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Shares one 4-bit ALU slice between two requesters and runs WIDTH-bit
// operations on it one nibble per cycle, LSB nibble first, chaining carry.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is expected to hold its payload until that
// edge (a requester may withdraw before it is granted), and ready never
// depends on a transfer in the same cycle on the same channel.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req0_op,
  input  logic [4:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [4:0]       alu_f
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = $clog2(NIB);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_op_t          op_q, op_d;
  logic             id_q, id_d;
  logic             carry_q, carry_d;

  logic [1:0]       gnt;
  logic             accept;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  // Only IDLE offers the grant; rst_n gates it so ready stays low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE)) begin
      req_ready = gnt;
    end
    accept = |(req_valid & req_ready);
  end

  // Next-state, operand latching and per-nibble result/carry capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    id_d    = id_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = 1'b0;
          if (req_ready[1]) begin
            a_d  = req1_a;
            b_d  = req1_b;
            op_d = req1_op;
            id_d = 1'b1;
          end else begin
            a_d  = req0_a;
            b_d  = req0_b;
            op_d = req0_op;
            id_d = 1'b0;
          end
        end
      end
      RUN: begin
        res_d[cnt_q*NIB_W +: NIB_W] = alu_f[3:0];
        carry_d = alu_f[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive the slice only while running; carry chains only in arithmetic mode past nibble 0.
  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_s   = 4'h0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a   = a_q[cnt_q*NIB_W +: NIB_W];
      alu_b   = b_q[cnt_q*NIB_W +: NIB_W];
      alu_s   = op_q.s;
      alu_m   = op_q.m;
      alu_cin = (cnt_q != '0) && !op_q.m && carry_q;
    end
  end

  // Response fields are held at zero except in RESP, where they come from stable registers.
  always_comb begin
    rsp_valid = (state_q == RESP);
    rsp_f     = rsp_valid ? res_q : '0;
    rsp_id    = rsp_valid & id_q;
    rsp_cout  = rsp_valid & carry_q & ~op_q.m;
    rsp_zero  = rsp_valid & ~|res_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      id_q    <= id_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a small ALU slice model, directed cases with
// hand-computed results, randomized traffic, and a per-cycle compare process
// driven by a word-level reference model.
module tb_alu_seq_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  localparam logic [4:0] OP_PASS_A = 5'b11111;
  localparam logic [4:0] OP_PASS_B = 5'b11010;
  localparam logic [4:0] OP_ADD    = 5'b01001;
  localparam logic [4:0] OP_SUB    = 5'b00110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
  logic [W-1:0] rsp_f;
  logic [3:0]   alu_a, alu_b, alu_s;
  logic         alu_m, alu_cin;
  logic [4:0]   alu_f;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic rand_rdy;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- ALU slice model ----------------
  // Logic mode reports a carry of 1 on purpose: the sequencer must ignore it.
  always_comb begin
    logic [4:0] t;
    t = 5'h00;
    if (alu_m) begin
      case (alu_s)
        4'hF:    t = {1'b1, alu_a};
        4'hA:    t = {1'b1, alu_b};
        default: t = {1'b1, alu_a ^ alu_b ^ alu_s};
      endcase
    end else if (alu_s == 4'h9) begin
      t = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    end else begin
      t = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
    end
    alu_f = t;
  end

  // ---------------- word-level reference ----------------
  function automatic logic [W:0] model_res(input logic [W-1:0] a, b, input logic [4:0] op);
    logic [W-1:0] s_rep;
    s_rep = {NIB{op[3:0]}};
    if (op[4]) begin
      if (op[3:0] == 4'hF) return {1'b0, a};
      if (op[3:0] == 4'hA) return {1'b0, b};
      return {1'b0, a ^ b ^ s_rep};
    end
    if (op[3:0] == 4'h9) return {1'b0, a} + {1'b0, b};
    return {1'b0, a} + {1'b0, ~b};
  endfunction

  // Carry into nibble k = carry out of the low 4k bits of the word-level sum.
  function automatic logic model_cin(input logic [W-1:0] a, b, input logic [4:0] op, input int k);
    logic [W:0] mask, sum;
    logic [W-1:0] bb;
    if (op[4] || k == 0) return 1'b0;
    bb   = (op[3:0] == 4'h9) ? b : ~b;
    mask = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
    sum  = ({1'b0, a} & mask) + ({1'b0, bb} & mask);
    return sum[4 * k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [W+2:0] exp_q[$];   // {id, cout, zero, f}
  int           m_k = -1;   // nibble being presented, -1 when not running
  logic         m_resp = 1'b0;
  logic         m_last = 1'b1;
  logic [W-1:0] m_a, m_b;
  logic [4:0]   m_op;
  logic [1:0]   m_g;
  logic [W:0]   m_r;
  logic [W+2:0] m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_cout, rsp_zero,
                            alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
      chk("reset_rsp_f", rsp_f, 0);
      m_k = -1; m_resp = 1'b0; m_last = 1'b1;
      exp_q.delete();
    end else if (m_k >= 0) begin
      chk("run_alu_a", alu_a, m_a[4*m_k +: 4]);
      chk("run_alu_b", alu_b, m_b[4*m_k +: 4]);
      chk("run_alu_op", {alu_m, alu_s}, m_op);
      chk("run_alu_cin", alu_cin, model_cin(m_a, m_b, m_op, m_k));
      chk("run_quiet", {req_ready, rsp_valid}, 0);
      m_k++;
      if (m_k == NIB) begin m_k = -1; m_resp = 1'b1; end
    end else if (m_resp) begin
      m_e = exp_q[0];
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_f", rsp_f, m_e[W-1:0]);
      chk("rsp_id", rsp_id, m_e[W+2]);
      chk("rsp_cout", rsp_cout, m_e[W+1]);
      chk("rsp_zero", rsp_zero, m_e[W]);
      chk("resp_quiet", {req_ready, alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
      if (rsp_ready) begin void'(exp_q.pop_front()); m_resp = 1'b0; end
    end else begin
      m_g = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
      chk("idle_req_ready", req_ready, m_g);
      chk("idle_quiet", {rsp_valid, alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
      if (|(req_valid & m_g)) begin
        m_last = m_g[1];
        m_a  = m_g[1] ? req1_a : req0_a;
        m_b  = m_g[1] ? req1_b : req0_b;
        m_op = m_g[1] ? req1_op : req0_op;
        m_r  = model_res(m_a, m_b, m_op);
        exp_q.push_back({m_g[1], m_r[W], (m_r[W-1:0] == '0), m_r[W-1:0]});
        m_k = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for a grant to any requester in mask; hs = edge count at the handshake edge.
  task automatic wait_grant(input logic [1:0] mask, output int hs);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (|(req_ready & req_valid & mask)) break;
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL grant_timeout: got no grant expected grant within 200 cycles");
    end
    @(posedge clk); #1;
    hs = cyc;
    req_valid = req_valid & ~mask;
    // Operands change right after the handshake; the DUT must not notice.
    req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 5'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 5'($urandom);
  endtask

  task automatic send(input int id, input logic [W-1:0] a, b, input logic [4:0] op, output int hs);
    @(posedge clk); #1;
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else begin req1_a = a; req1_b = b; req1_op = op; end
    req_valid[id] = 1'b1;
    wait_grant(2'b01 << id, hs);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic directed(input int id, input logic [W-1:0] a, b, input logic [4:0] op,
                          input logic [W-1:0] ef, input logic ecout, ezero,
                          input logic [NIB-1:0] ecins, input string tag);
    int hs;
    logic [NIB-1:0] cins;
    send(id, a, b, op, hs);
    for (int k = 0; k < NIB; k++) begin @(negedge clk); cins[k] = alu_cin; end
    @(negedge clk);
    wait_rsp();
    // rsp_valid is first seen in the cycle after edge hs+NIB.
    chk({tag, "_latency"}, cyc - hs, NIB);
    chk({tag, "_f"}, rsp_f, ef);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_cout"}, rsp_cout, ecout);
    chk({tag, "_zero"}, rsp_zero, ezero);
    chk({tag, "_cin_per_nibble"}, cins, ecins);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- main sequence ----------------
  logic [W-1:0] cap_f;
  logic [2:0]   cap_bits;
  logic [3:0]   order;
  int           hsv[4];
  int           hs, c0, n;
  logic [4:0]   ops[4];

  initial begin
    ops[0] = OP_PASS_A; ops[1] = OP_PASS_B; ops[2] = OP_ADD; ops[3] = OP_SUB;
    rst_n = 1'b0; rand_rdy = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b11;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready_held_valid", req_ready, 2'b00);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Directed cases with hand-computed results.
    directed(0, 16'h1234, 16'hBEEF, OP_PASS_A, 16'h1234, 1'b0, 1'b0, 4'b0000, "pass_a");
    directed(1, 16'h00FF, 16'h0001, OP_ADD,    16'h0100, 1'b0, 1'b0, 4'b0110, "add_carry_chain");
    directed(0, 16'hFFFF, 16'h0001, OP_ADD,    16'h0000, 1'b1, 1'b1, 4'b1110, "add_wrap");
    directed(1, 16'h5A5A, 16'h0000, OP_PASS_B, 16'h0000, 1'b0, 1'b1, 4'b0000, "pass_b_zero");
    directed(0, 16'h1000, 16'h0001, OP_SUB,    16'h0FFE, 1'b1, 1'b0, 4'b0000, "sub_nibbles");

    // Both requesters held: round-robin from reset gives 0,1,0,1 at NIB+2 spacing.
    do_reset();
    req0_a = 16'hA0A0; req0_b = 16'h0000; req0_op = OP_PASS_A;
    req1_a = 16'h0000; req1_b = 16'h0B0B; req1_op = OP_PASS_B;
    @(posedge clk); #1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 50);
      order[i] = req_ready[1];
      @(posedge clk); #1;
      hsv[i] = cyc;
    end
    req_valid = 2'b00;
    chk("rr_order", order, 4'b1010);
    for (int i = 1; i < 4; i++) chk("rr_spacing", hsv[i] - hsv[i-1], NIB + 2);

    // Back-pressure: response must hold still and the block must not accept.
    repeat (NIB + 3) @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(0, 16'h0F0F, 16'h0101, OP_ADD, hs);
    @(negedge clk);
    wait_rsp();
    cap_f = rsp_f; cap_bits = {rsp_id, rsp_cout, rsp_zero};
    chk("bp_first_f", cap_f, 16'h1010);
    req1_a = 16'h7777; req1_b = 16'h0000; req1_op = OP_PASS_A;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_f", rsp_f, cap_f);
      chk("bp_hold_bits", {rsp_id, rsp_cout, rsp_zero}, cap_bits);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    c0 = cyc;
    wait_grant(2'b10, hs);
    // Response handshake on the next edge, then one IDLE cycle before the accept.
    chk("bp_next_accept_edge", hs - c0, 2);
    repeat (NIB + 3) @(posedge clk);

    // Asynchronous reset while nibble 2 is on the slice.
    send(0, 16'h8421, 16'h1248, OP_ADD, hs);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_reset_nibble2", alu_a, 4'h4);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {req_ready, rsp_valid, rsp_id, rsp_cout, rsp_zero,
                             alu_a, alu_b, alu_s, alu_m, alu_cin}, 0);
    chk("async_reset_f", rsp_f, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * NIB + 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    directed(1, 16'h4321, 16'h1111, OP_ADD, 16'h5432, 1'b0, 1'b0, 4'b0000, "post_reset");

    // Randomized traffic against the reference model.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      req0_a = W'($urandom); req0_b = W'($urandom); req0_op = ops[$urandom_range(0, 3)];
      req1_a = W'($urandom); req1_b = W'($urandom); req1_op = ops[$urandom_range(0, 3)];
      req_valid = 2'($urandom_range(1, 3));
      wait_grant(2'b11, hs);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || m_k >= 0) && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
